// File: rtl/seq_det_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl_if
// Host-side bundle for the serial pattern-detector controller.
//   master : host / driver (drives configuration, run control, serial data)
//   slave  : seq_det_ctrl  (drives detect pulse, status and counters)
// Signals:
//   cfg_we, cfg_pattern, cfg_threshold, cfg_window : configuration load
//   start, abort                                   : run control
//   inp, inp_valid                                 : qualified serial input
//   det                                            : Mealy match pulse
//   busy, match_cnt                                : run status
//   done, done_status, done_ack                    : completion handshake
// -----------------------------------------------------------------------------
interface seq_det_ctrl_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
);
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_threshold;
  logic [WIN_W-1:0] cfg_window;
  logic             start;
  logic             abort;
  logic             inp;
  logic             inp_valid;
  logic             det;
  logic             busy;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic [1:0]       done_status;
  logic             done_ack;

  modport master (
    output cfg_we, cfg_pattern, cfg_threshold, cfg_window,
    output start, abort, inp, inp_valid, done_ack,
    input  det, busy, match_cnt, done, done_status
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_threshold, cfg_window,
    input  start, abort, inp, inp_valid, done_ack,
    output det, busy, match_cnt, done, done_status
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
// Arms, configures and supervises an overlapping Mealy serial pattern detector.
// A run is started from IDLE, counts matches while ARMED and finishes on abort,
// match threshold or cycle-window timeout, then waits in DONE for done_ack.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : seq_det_ctrl_if slave modport (config, run control, serial data,
//           detect pulse, match count and done/ack handshake)
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  seq_det_ctrl_if.slave bus
);

  localparam int HIST_W = PAT_W - 1;
  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HIST_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ST_NONE      = 2'b00,
    ST_THRESHOLD = 2'b01,
    ST_TIMEOUT   = 2'b10,
    ST_ABORT     = 2'b11
  } status_e;

  state_e            state_q,   state_d;
  status_e           status_q,  status_d;
  logic [PAT_W-1:0]  pat_q,     pat_d;
  logic [CNT_W-1:0]  thr_q,     thr_d;
  logic [WIN_W-1:0]  win_q,     win_d;
  logic [HIST_W-1:0] hist_q,    hist_d;
  logic [FILL_W-1:0] fill_q,    fill_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;

  logic             det;
  logic [PAT_W-1:0] window_bits;
  logic [CNT_W:0]   cnt_inc;
  logic             thr_hit;
  logic             timeout;

  // Newest bit is the LSB, so the oldest history bit lines up with the
  // pattern MSB.
  assign window_bits = {hist_q, bus.inp};

  assign det = (state_q == ARMED) && bus.inp_valid && (fill_q >= FILL_FULL) &&
               (window_bits == pat_q);

  // One bit wider so a count of all-ones plus this match cannot wrap below
  // the threshold.
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign thr_hit = (thr_q != '0) && det && (cnt_inc >= {1'b0, thr_q});
  assign timeout = (win_q != '0) && (win_cnt_q == win_q - 1'b1);

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d   = state_q;
    status_d  = status_q;
    pat_d     = pat_q;
    thr_d     = thr_q;
    win_d     = win_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    win_cnt_d = win_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_we) begin
          pat_d = bus.cfg_pattern;
          thr_d = bus.cfg_threshold;
          win_d = bus.cfg_window;
        end
        if (bus.start) begin
          state_d   = ARMED;
          status_d  = ST_NONE;
          hist_d    = '0;
          fill_d    = '0;
          cnt_d     = '0;
          win_cnt_d = '0;
        end
      end

      ARMED: begin
        if (bus.inp_valid) begin
          hist_d = window_bits[HIST_W-1:0];
          if (fill_q < FILL_FULL) fill_d = fill_q + 1'b1;
        end
        if (det && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        win_cnt_d = win_cnt_q + 1'b1;

        if (bus.abort) begin
          state_d  = DONE;
          status_d = ST_ABORT;
        end else if (thr_hit) begin
          state_d  = DONE;
          status_d = ST_THRESHOLD;
        end else if (timeout) begin
          state_d  = DONE;
          status_d = ST_TIMEOUT;
        end
      end

      DONE: begin
        if (bus.done_ack) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!reset) begin
      state_q   <= IDLE;
      status_q  <= ST_NONE;
      pat_q     <= PAT_W'(1);
      thr_q     <= CNT_W'(1);
      win_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      pat_q     <= pat_d;
      thr_q     <= thr_d;
      win_q     <= win_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  assign bus.det         = det;
  assign bus.busy        = (state_q == ARMED);
  assign bus.done        = (state_q == DONE);
  assign bus.done_status = status_q;
  assign bus.match_cnt   = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
// Self-checking bench for seq_det_ctrl: directed scenarios with literal
// expectations, then a randomized phase. A behavioural model (bit queue plus
// run flags) predicts all outputs and is compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

  localparam int PAT_W = 3;
  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int det_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: state during the current cycle.
  // ---------------------------------------------------------------------------
  bit m_valid = 0;   // set once a reset edge has defined the DUT state
  bit m_run   = 0;
  bit m_fin   = 0;
  int m_status, m_cnt, m_cycles;
  int m_pat, m_thr, m_win;
  bit m_bits[$];     // valid bits received in the current run

  always @(negedge clk) begin
    bit det_e;
    int v;
    int old_cnt;
    det_e = 0;
    if (m_run && bus.inp_valid && (m_bits.size() >= PAT_W - 1)) begin
      v = 0;
      for (int i = PAT_W - 1; i >= 1; i--) v = v * 2 + int'(m_bits[m_bits.size() - i]);
      v = v * 2 + int'(bus.inp);
      det_e = (v == m_pat);
    end
    if (bus.det === 1'b1) det_seen++;

    if (m_valid) begin
      check("det",         32'(bus.det),         32'(det_e));
      check("busy",        32'(bus.busy),        32'(m_run));
      check("done",        32'(bus.done),        32'(m_fin));
      check("done_status", 32'(bus.done_status), 32'(m_status));
      check("match_cnt",   32'(bus.match_cnt),   32'(m_cnt));
    end

    // Advance the model to the state after the coming rising edge.
    if (!reset) begin
      m_valid = 1; m_run = 0; m_fin = 0; m_status = 0; m_cnt = 0; m_cycles = 0;
      m_pat = 1; m_thr = 1; m_win = 0;
      m_bits.delete();
    end else if (m_run) begin
      old_cnt = m_cnt;
      if (det_e && m_cnt < CNT_MAX) m_cnt++;
      if (bus.inp_valid) begin
        m_bits.push_back(bus.inp);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      end
      m_cycles++;
      if (bus.abort) begin
        m_run = 0; m_fin = 1; m_status = 3;
      end else if (m_thr != 0 && det_e && old_cnt + 1 >= m_thr) begin
        m_run = 0; m_fin = 1; m_status = 1;
      end else if (m_win != 0 && m_cycles == m_win) begin
        m_run = 0; m_fin = 1; m_status = 2;
      end
    end else if (m_fin) begin
      if (bus.done_ack) m_fin = 0;
    end else begin
      if (bus.cfg_we) begin
        m_pat = int'(bus.cfg_pattern);
        m_thr = int'(bus.cfg_threshold);
        m_win = int'(bus.cfg_window);
      end
      if (bus.start) begin
        m_run = 1; m_status = 0; m_cnt = 0; m_cycles = 0;
        m_bits.delete();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input bit b);
    bus.inp = b;
    bus.inp_valid = 1'b1;
    cyc();
  endtask

  task automatic configure(input int pat, input int thr, input int win);
    bus.cfg_we        = 1'b1;
    bus.cfg_pattern   = PAT_W'(pat);
    bus.cfg_threshold = CNT_W'(thr);
    bus.cfg_window    = WIN_W'(win);
    cyc();
    bus.cfg_we = 1'b0;
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic ack();
    bus.inp_valid = 1'b0;
    bus.done_ack  = 1'b1;
    cyc();
    bus.done_ack  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    check("wait_done", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int d0;
    int n;
    bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_threshold = 0; bus.cfg_window = 0;
    bus.start = 0; bus.abort = 0; bus.inp = 0; bus.inp_valid = 0; bus.done_ack = 0;
    reset = 1'b0;

    // Reset defaults
    cyc(); cyc();
    check("rst_busy",   32'(bus.busy),        32'd0);
    check("rst_done",   32'(bus.done),        32'd0);
    check("rst_status", 32'(bus.done_status), 32'd0);
    check("rst_cnt",    32'(bus.match_cnt),   32'd0);
    check("rst_det",    32'(bus.det),         32'd0);
    reset = 1'b1;
    cyc();

    // Default pattern 001, threshold 1
    d0 = det_seen;
    start_run();
    check("s1_busy", 32'(bus.busy), 32'd1);
    feed(0); feed(0); feed(1);
    bus.inp_valid = 0;
    check("s1_done",   32'(bus.done),        32'd1);
    check("s1_status", 32'(bus.done_status), 32'd1);
    check("s1_cnt",    32'(bus.match_cnt),   32'd1);
    check("s1_dets",   32'(det_seen - d0),   32'd1);
    ack();
    check("s1_ack", 32'(bus.done), 32'd0);

    // Overlap and valid gaps
    configure(3'b001, 3, 0);
    d0 = det_seen;
    start_run();
    feed(0); feed(0); feed(1); feed(0); feed(0); feed(0);
    bus.inp_valid = 0;
    bus.inp = 1'($urandom); cyc();
    bus.inp = 1'($urandom); cyc();
    feed(1); feed(0); feed(0); feed(1);
    bus.inp_valid = 0;
    check("s2_done",   32'(bus.done),        32'd1);
    check("s2_status", 32'(bus.done_status), 32'd1);
    check("s2_cnt",    32'(bus.match_cnt),   32'd3);
    check("s2_dets",   32'(det_seen - d0),   32'd3);
    ack();

    // Timeout: ARMED lasts exactly window cycles
    configure(3'b001, 5, 10);
    bus.inp = 1; bus.inp_valid = 1;
    start_run();
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
    bus.inp_valid = 0;
    check("s3_armed_cycles", 32'(n),                32'd10);
    check("s3_done",         32'(bus.done),         32'd1);
    check("s3_status",       32'(bus.done_status),  32'd2);
    check("s3_cnt",          32'(bus.match_cnt),    32'd0);
    ack();

    // Abort wins over a threshold-reaching match in the same cycle
    configure(3'b001, 1, 0);
    start_run();
    feed(0); feed(0);
    bus.abort = 1;
    feed(1);
    bus.abort = 0; bus.inp_valid = 0;
    check("s4a_status", 32'(bus.done_status), 32'd3);
    ack();

    // Threshold reached on the final window cycle
    configure(3'b001, 1, 5);
    start_run();
    feed(1); feed(1); feed(0); feed(0); feed(1);
    bus.inp_valid = 0;
    check("s4b_done",   32'(bus.done),        32'd1);
    check("s4b_status", 32'(bus.done_status), 32'd1);
    ack();

    // Guards: cfg_we/start in ARMED, start in DONE, next start clears count
    configure(3'b001, 2, 0);
    start_run();
    bus.cfg_we = 1; bus.cfg_pattern = 3'b111; bus.cfg_threshold = 1; bus.cfg_window = 3;
    bus.start = 1;
    cyc();
    bus.cfg_we = 0; bus.start = 0;
    feed(0); feed(0); feed(1);
    check("s5_not_done", 32'(bus.done),      32'd0);
    check("s5_cnt1",     32'(bus.match_cnt), 32'd1);
    feed(0); feed(0); feed(1);
    bus.inp_valid = 0;
    check("s5_status", 32'(bus.done_status), 32'd1);
    bus.start = 1; cyc(); cyc(); bus.start = 0;
    check("s5_start_in_done", 32'(bus.done), 32'd1);
    ack();
    check("s5_ack_done",  32'(bus.done),      32'd0);
    check("s5_keep_cnt",  32'(bus.match_cnt), 32'd2);
    start_run();
    check("s5_cnt_clear", 32'(bus.match_cnt), 32'd0);
    bus.abort = 1; cyc(); bus.abort = 0;
    ack();

    // Reset mid-run restores the default pattern
    configure(3'b101, 5, 0);
    start_run();
    feed(1); feed(0); feed(1); feed(0); feed(1);
    bus.inp_valid = 0;
    check("s6_cnt2", 32'(bus.match_cnt), 32'd2);
    reset = 0; cyc(); reset = 1;
    check("s6_busy", 32'(bus.busy),      32'd0);
    check("s6_cnt",  32'(bus.match_cnt), 32'd0);
    d0 = det_seen;
    start_run();
    feed(1); feed(0); feed(1); feed(0); feed(0); feed(1);
    bus.inp_valid = 0;
    check("s6_dets",   32'(det_seen - d0),   32'd1);
    check("s6_status", 32'(bus.done_status), 32'd1);
    ack();

    // Randomized phase, checked by the model
    for (int c = 0; c < 3000; c++) begin
      reset             = ($urandom_range(0, 199) != 0);
      bus.cfg_we        = ($urandom_range(0, 9) == 0);
      bus.cfg_pattern   = PAT_W'($urandom);
      bus.cfg_threshold = CNT_W'($urandom_range(0, 4));
      bus.cfg_window    = ($urandom_range(0, 3) == 0) ? '0 : WIN_W'($urandom_range(1, 25));
      bus.start         = ($urandom_range(0, 5) == 0);
      bus.abort         = ($urandom_range(0, 39) == 0);
      bus.inp           = 1'($urandom);
      bus.inp_valid     = ($urandom_range(0, 3) != 0);
      bus.done_ack      = ($urandom_range(0, 3) == 0);
      cyc();
    end
    reset = 1; bus.cfg_we = 0; bus.start = 0; bus.abort = 0;
    bus.inp_valid = 0; bus.done_ack = 0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
